// File: rtl/led_pkg.sv
// Shared LED pattern definitions: mode encodings and the default PWM period.
package led_pkg;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_FULL    = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_CHASE   = 2'd3;

    localparam int unsigned DUTY_MAX_DEF = 25000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser and debouncer with a 1-cycle rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise
);

    localparam int unsigned     CNT_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;

    // The count only runs while the synced level disagrees with the accepted
    // level, so any bounce back restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_s1   <= btn_in;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_cnt   <= '0;
                r_level <= r_s2;
                r_rise  <= r_s2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/breathe_ctrl.sv
// Per-channel LED duty generator (OFF/FULL/BREATHE/CHASE), updated only at
// PWM period boundaries; mode is cycled by a debounced push button.
module breathe_ctrl
    import led_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DUTY_W       = 16,
    parameter int unsigned DUTY_MAX     = DUTY_MAX_DEF,
    parameter int unsigned STEP         = 10,
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn,
    input  logic                     period_done,
    output logic [NUM_CH*DUTY_W-1:0] duty_out,
    output logic                     duty_valid,
    output logic [1:0]               mode
);

    localparam int unsigned       SUM_W     = DUTY_W + 2;
    localparam int unsigned       OFS       = (2 * DUTY_MAX) / NUM_CH;
    localparam logic [SUM_W-1:0]  C_TWO_MAX = SUM_W'(2 * DUTY_MAX);
    localparam logic [SUM_W-1:0]  C_MAX     = SUM_W'(DUTY_MAX);
    localparam logic [SUM_W-1:0]  C_STEP    = SUM_W'(STEP);

    logic [NUM_CH*DUTY_W-1:0] r_duty;
    logic                     r_valid;
    logic [1:0]               r_mode;
    logic [1:0]               r_pend_mode;
    logic [DUTY_W:0]          r_phase;

    logic                     w_rise;
    logic                     w_level;
    logic [SUM_W-1:0]         w_sum;
    logic [DUTY_W:0]          w_phase_n;
    logic [SUM_W-1:0]         w_chs;
    logic [NUM_CH*DUTY_W-1:0] w_duty_n;
    logic                     w_anim;

    function automatic logic [DUTY_W-1:0] tri_fold(input logic [SUM_W-1:0] x);
        logic [SUM_W-1:0] y;
        y = (x <= C_MAX) ? x : (C_TWO_MAX - x);
        return y[DUTY_W-1:0];
    endfunction

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn_in(btn),
        .level (w_level),
        .rise  (w_rise)
    );

    // Next phase and duties, computed against the mode about to be applied.
    always_comb begin
        w_anim = (r_pend_mode == MODE_BREATHE) || (r_pend_mode == MODE_CHASE);
        w_sum  = {1'b0, r_phase} + C_STEP;
        if (w_sum >= C_TWO_MAX) begin
            w_sum = w_sum - C_TWO_MAX;
        end
        w_phase_n = (r_pend_mode != r_mode) ? C_STEP[DUTY_W:0] : w_sum[DUTY_W:0];
        w_chs     = '0;
        w_duty_n  = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            w_chs = {1'b0, w_phase_n};
            if (r_pend_mode == MODE_CHASE) begin
                w_chs = w_chs + SUM_W'(32'(i) * OFS);
            end
            if (w_chs >= C_TWO_MAX) begin
                w_chs = w_chs - C_TWO_MAX;
            end
            case (r_pend_mode)
                MODE_OFF:  w_duty_n[i*DUTY_W +: DUTY_W] = '0;
                MODE_FULL: w_duty_n[i*DUTY_W +: DUTY_W] = C_MAX[DUTY_W-1:0];
                default:   w_duty_n[i*DUTY_W +: DUTY_W] = tri_fold(w_chs);
            endcase
        end
    end

    // A same-cycle button edge only reaches pend_mode, so it is applied next period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty      <= '0;
            r_valid     <= 1'b0;
            r_mode      <= MODE_BREATHE;
            r_pend_mode <= MODE_BREATHE;
            r_phase     <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_rise) begin
                r_pend_mode <= r_pend_mode + 2'd1;
            end
            if (period_done) begin
                r_mode  <= r_pend_mode;
                r_valid <= 1'b1;
                r_duty  <= w_duty_n;
                if (w_anim) begin
                    r_phase <= w_phase_n;
                end
            end
        end
    end

    assign duty_out   = r_duty;
    assign duty_valid = r_valid;
    assign mode       = r_mode;

endmodule

// File: tb/tb_breathe_ctrl.sv
// Directed self-checking bench for breathe_ctrl with small bench parameters.
module tb_breathe_ctrl;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DUTY_W = 8;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     btn = 1'b0;
    logic                     period_done = 1'b0;
    logic [NUM_CH*DUTY_W-1:0] duty_out;
    logic                     duty_valid;
    logic [1:0]               mode;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          n_pulses;
        logic [31:0] exp_duty;
        logic [1:0]  exp_mode;
    } ramp_vec_t;

    ramp_vec_t ramp[5];

    breathe_ctrl #(
        .NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .DUTY_MAX(100), .STEP(10), .DEBOUNCE_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .period_done(period_done),
        .duty_out(duty_out), .duty_valid(duty_valid), .mode(mode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One period_done pulse; on return the outputs of that pulse are visible.
    task automatic pulse();
        @(negedge clk) period_done = 1'b1;
        @(negedge clk) period_done = 1'b0;
    endtask

    task automatic pulse_check(input string name, input logic [31:0] exp_duty, input logic [1:0] exp_mode);
        pulse();
        check({name, " valid"}, 32'(duty_valid), 32'd1);
        check({name, " duty"}, duty_out, exp_duty);
        check({name, " mode"}, 32'(mode), 32'(exp_mode));
    endtask

    task automatic press(input int cycles);
        @(negedge clk) btn = 1'b1;
        repeat (cycles) @(negedge clk);
        btn = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    logic [31:0] held;
    int          bad;

    initial begin
        ramp[0] = '{1, pack4(10, 10, 10, 10), 2'd2};
        ramp[1] = '{9, pack4(100, 100, 100, 100), 2'd2};
        ramp[2] = '{1, pack4(90, 90, 90, 90), 2'd2};
        ramp[3] = '{9, pack4(0, 0, 0, 0), 2'd2};
        ramp[4] = '{1, pack4(10, 10, 10, 10), 2'd2};

        repeat (3) @(negedge clk);
        check("reset duty", duty_out, 32'd0);
        check("reset valid", 32'(duty_valid), 32'd0);
        check("reset mode", 32'(mode), 32'd2);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // BREATHE ramp including the fold at 100 and the wrap at 200
        for (int v = 0; v < 5; v++) begin
            repeat (ramp[v].n_pulses - 1) pulse();
            pulse_check($sformatf("ramp%0d", v), ramp[v].exp_duty, ramp[v].exp_mode);
            @(negedge clk);
            check($sformatf("ramp%0d valid drop", v), 32'(duty_valid), 32'd0);
        end

        held = duty_out;
        bad  = 0;
        repeat (50) begin
            @(negedge clk);
            if (duty_out !== held || duty_valid !== 1'b0) bad++;
        end
        check("hold 50 cycles", 32'(bad), 32'd0);

        // CHASE entry restarts phase at STEP
        press(12);
        check("mode before pulse", 32'(mode), 32'd2);
        pulse_check("chase entry", pack4(10, 60, 90, 40), 2'd3);

        // Short press rejected; phase keeps advancing in CHASE
        press(5);
        pulse_check("short press", pack4(20, 70, 80, 30), 2'd3);

        press(12);
        check("mode held until pulse", 32'(mode), 32'd3);
        pulse_check("walk off", pack4(0, 0, 0, 0), 2'd0);
        press(12);
        pulse_check("walk full", pack4(100, 100, 100, 100), 2'd1);
        press(12);
        pulse_check("walk breathe", pack4(10, 10, 10, 10), 2'd2);

        // Debounced rise lands in the same cycle as period_done
        @(negedge clk) btn = 1'b1;
        repeat (10) @(negedge clk);
        period_done = 1'b1;
        @(negedge clk) period_done = 1'b0;
        check("collision mode", 32'(mode), 32'd2);
        check("collision duty", duty_out, pack4(20, 20, 20, 20));
        btn = 1'b0;
        repeat (20) @(negedge clk);
        pulse_check("after collision", pack4(10, 60, 90, 40), 2'd3);

        // Back-to-back pulses each advance the phase
        @(negedge clk) period_done = 1'b1;
        @(negedge clk);
        check("b2b first", duty_out, pack4(20, 70, 80, 30));
        @(negedge clk) period_done = 1'b0;
        check("b2b second", duty_out, pack4(30, 80, 70, 20));

        // Async reset mid-ramp
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        repeat (6) pulse();
        pulse_check("pre-reset ramp", pack4(70, 70, 70, 70), 2'd2);
        #2 rst = 1'b1;
        #1;
        check("async reset duty", duty_out, 32'd0);
        check("async reset mode", 32'(mode), 32'd2);
        check("async reset valid", 32'(duty_valid), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        pulse_check("post-reset", pack4(10, 10, 10, 10), 2'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
